fsm_out_rle: RTL and testbench

//   Run-length encoder placed directly downstream of awful_fsm; consumes its 3-bit out code stream.

---
 rtl/fsm_pkg.sv | 22 ++
 rtl/rle_fifo.sv | 65 ++++++
 rtl/fsm_out_rle.sv | 114 +++++++++++
 tb/tb_fsm_out_rle.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the awful_fsm output path: code width, code constants,
// run-length controller states and the {code,len} record layout.
package fsm_pkg;

  localparam int unsigned CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_ZERO = '0;
  localparam code_t CODE_ALL1 = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rle_state_e;

  // Records are packed code-high, length-low.
  function automatic int unsigned rec_w(input int unsigned run_w);
    return CODE_W + run_w;
  endfunction

endpackage

// File: rtl/rle_fifo.sv
// Synchronous show-ahead FIFO holding run-length records, with occupancy
// count and full/empty flags.
module rle_fifo #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          rd_ready,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic [W-1:0]  last_q, last_d;
  logic [W-1:0]  head;
  logic          pop;
  logic          wr_en;

  assign level = wr_cnt_q - rd_cnt_q;
  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign valid = ~empty;
  assign head  = mem_q[rd_cnt_q[AW-1:0]];
  // The slot under rd_cnt is stale once drained, so the last popped head is replayed.
  assign rdata = empty ? last_q : head;

  always_comb begin
    mem_d    = mem_q;
    pop      = ~empty & rd_ready;
    wr_en    = push & (~full | pop);
    wr_cnt_d = wr_cnt_q + (AW+1)'(wr_en);
    rd_cnt_d = rd_cnt_q + (AW+1)'(pop);
    last_d   = pop ? head : last_q;
    if (wr_en) begin
      mem_d[wr_cnt_q[AW-1:0]] = wdata;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem_q    <= '{default: '0};
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/fsm_out_rle.sv
// Run-length encoder for the awful_fsm code stream: folds runs of identical
// codes into {code,len} records and queues them for a stallable consumer.
module fsm_out_rle
  import fsm_pkg::*;
#(
  parameter int unsigned RUN_W = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              sample_en,
  input  logic [CODE_W-1:0] sym_in,
  input  logic              flush,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [CODE_W-1:0] rec_code,
  output logic [RUN_W-1:0]  rec_len,
  output logic [AW:0]       level,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int unsigned REC_W   = rec_w(RUN_W);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  rle_state_e        state_q, state_d;
  logic [CODE_W-1:0] cur_q, cur_d;
  logic [RUN_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REC_W-1:0]  rec_data;

  // Every push closes the currently open run, so the record is always {cur,cnt}.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (flush) begin
      if (state_q == ST_RUN) begin
        push = 1'b1;
      end
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (sample_en) begin
      unique case (state_q)
        ST_IDLE: begin
          cur_d   = sym_in;
          cnt_d   = RUN_ONE;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (sym_in == cur_q) begin
            if (cnt_q == RUN_MAX) begin
              push  = 1'b1;
              cnt_d = RUN_ONE;
            end else begin
              cnt_d = cnt_q + RUN_ONE;
            end
          end else begin
            push  = 1'b1;
            cur_d = sym_in;
            cnt_d = RUN_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign drop  = push & fifo_full & ~(rec_valid & rec_ready);
  assign ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  assign ovf   = ovf_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  rle_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .clr_n    (clr_n),
    .push     (push),
    .wdata    ({cur_q, cnt_q}),
    .rd_ready (rec_ready),
    .rdata    (rec_data),
    .valid    (rec_valid),
    .level    (level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rec_code = rec_data[RUN_W +: CODE_W];
  assign rec_len  = fifo_empty ? rec_data[RUN_W-1:0] : rec_data[RUN_W-1:0];

endmodule

// File: tb/tb_fsm_out_rle.sv
// Directed bench for fsm_out_rle: a default instance (RUN_W=8) and a narrow
// instance (RUN_W=3) share one stimulus stream.
module tb_fsm_out_rle;
  import fsm_pkg::*;

  logic              clk = 1'b0;
  logic              clr_n;
  logic              sample_en;
  logic [CODE_W-1:0] sym_in;
  logic              flush;
  logic              rec_ready;
  logic              ovf_clr;

  logic              rec_valid, s_valid;
  logic [CODE_W-1:0] rec_code, s_code;
  logic [7:0]        rec_len;
  logic [2:0]        s_len;
  logic [2:0]        level, s_level;
  logic              ovf, s_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_out_rle dut (
    .clk(clk), .clr_n(clr_n), .sample_en(sample_en), .sym_in(sym_in),
    .flush(flush), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_code(rec_code), .rec_len(rec_len), .level(level), .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  fsm_out_rle #(.RUN_W(3), .DEPTH(4), .AW(2)) dut_s (
    .clk(clk), .clr_n(clr_n), .sample_en(sample_en), .sym_in(sym_in),
    .flush(flush), .rec_valid(s_valid), .rec_ready(rec_ready),
    .rec_code(s_code), .rec_len(s_len), .level(s_level), .ovf(s_ovf),
    .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic       se;
    logic [2:0] sym;
    logic       fl;
    logic       rdy;
    logic       oc;
    int         ev;
    int         ec;
    int         el;
    int         elv;
    int         eo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int se, input int sym, input int fl, input int rdy, input int oc);
    sample_en = se[0];
    sym_in    = sym[2:0];
    flush     = fl[0];
    rec_ready = rdy[0];
    ovf_clr   = oc[0];
  endtask

  task automatic addv(input int se, input int sym, input int fl, input int rdy, input int oc,
                      input int ev, input int ec, input int el, input int elv, input int eo);
    vec_t v;
    v.se = se[0]; v.sym = sym[2:0]; v.fl = fl[0]; v.rdy = rdy[0]; v.oc = oc[0];
    v.ev = ev; v.ec = ec; v.el = el; v.elv = elv; v.eo = eo;
    tbl.push_back(v);
  endtask

  task automatic chk_head(input string tag, input int ev, input int ec, input int el, input int elv);
    chk({tag, "_valid"}, int'(rec_valid), ev);
    chk({tag, "_code"},  int'(rec_code),  ec);
    chk({tag, "_len"},   int'(rec_len),   el);
    chk({tag, "_level"}, int'(level),     elv);
  endtask

  task automatic chk_head_s(input string tag, input int ev, input int ec, input int el, input int elv);
    chk({tag, "_s_valid"}, int'(s_valid), ev);
    chk({tag, "_s_code"},  int'(s_code),  ec);
    chk({tag, "_s_len"},   int'(s_len),   el);
    chk({tag, "_s_level"}, int'(s_level), elv);
  endtask

  initial begin
    // Basic runs 2,2,2,5,5,1 + flush with the consumer always ready.
    addv(1,2,0,1,0, 0,0,0,0,0);
    addv(1,2,0,1,0, 0,0,0,0,0);
    addv(1,2,0,1,0, 0,0,0,0,0);
    addv(1,5,0,1,0, 1,2,3,1,0);
    addv(1,5,0,1,0, 0,2,3,0,0);
    addv(1,1,0,1,0, 1,5,2,1,0);
    addv(0,0,1,1,0, 1,1,1,1,0);
    addv(0,0,0,1,0, 0,1,1,0,0);
    // Backpressure: codes 0..6, four records fit, two are dropped.
    addv(1,0,0,0,0, 0,1,1,0,0);
    addv(1,1,0,0,0, 1,0,1,1,0);
    addv(1,2,0,0,0, 1,0,1,2,0);
    addv(1,3,0,0,0, 1,0,1,3,0);
    addv(1,4,0,0,0, 1,0,1,4,0);
    addv(1,5,0,0,0, 1,0,1,4,1);
    addv(1,6,0,0,1, 1,0,1,4,1);
    addv(0,0,0,0,0, 1,0,1,4,1);
    addv(0,0,0,0,1, 1,0,1,4,0);
    // Full with pop and push together, then drain in order, then idle-ready on empty.
    addv(0,0,1,1,0, 1,1,1,4,0);
    addv(0,0,0,1,0, 1,2,1,3,0);
    addv(0,0,0,1,0, 1,3,1,2,0);
    addv(0,0,0,1,0, 1,6,1,1,0);
    addv(0,0,0,1,0, 0,6,1,0,0);
    addv(0,0,0,1,0, 0,6,1,0,0);

    clr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(int'($urandom_range(0,1)), int'($urandom_range(0,7)), int'($urandom_range(0,1)),
            int'($urandom_range(0,1)), int'($urandom_range(0,1)));
      tick();
      chk_head($sformatf("rst%0d", i), 0, 0, 0, 0);
      chk($sformatf("rst%0d_ovf", i), int'(ovf), 0);
      chk($sformatf("rst%0d_s_valid", i), int'(s_valid), 0);
    end
    drive(0,0,0,0,0);
    clr_n = 1'b1;
    tick();
    chk_head("post_rst", 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(int'(tbl[i].se), int'(tbl[i].sym), int'(tbl[i].fl), int'(tbl[i].rdy), int'(tbl[i].oc));
      tick();
      chk_head($sformatf("t%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].el, tbl[i].elv);
      chk($sformatf("t%0d_ovf", i), int'(ovf), tbl[i].eo);
      chk_head_s($sformatf("t%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].el, tbl[i].elv);
      chk($sformatf("t%0d_s_ovf", i), int'(s_ovf), tbl[i].eo);
    end

    // Saturation: nine 4s; narrow instance caps at 7, wide one counts to 9.
    for (int i = 1; i <= 9; i++) begin
      drive(1,4,0,0,0);
      tick();
      if (i == 8) begin
        chk_head_s("sat8", 1, 4, 7, 1);
        chk("sat8_level", int'(level), 0);
      end
    end
    drive(0,0,1,0,0);
    tick();
    chk_head_s("sat_fl", 1, 4, 7, 2);
    chk_head("sat_fl", 1, 4, 9, 1);
    drive(0,0,0,1,0);
    tick();
    chk_head_s("sat_pop1", 1, 4, 2, 1);
    chk_head("sat_pop1", 0, 4, 9, 0);
    tick();
    chk_head_s("sat_pop2", 0, 4, 2, 0);

    // Flush collides with a different-code sample.
    drive(1,3,0,0,0);
    tick();
    tick();
    chk_head("col_open", 0, 4, 9, 0);
    drive(1,5,1,0,0);
    tick();
    chk_head("col_fl", 1, 3, 2, 1);
    drive(0,0,0,0,0);
    tick();
    chk_head("col_after", 1, 3, 2, 1);
    drive(0,0,1,0,0);
    tick();
    chk_head("col_idle_fl", 1, 3, 2, 1);
    drive(1,7,0,0,0);
    tick();
    chk_head("col_new", 1, 3, 2, 1);
    drive(0,0,1,0,0);
    tick();
    chk_head("col_new_fl", 1, 3, 2, 2);
    drive(0,0,0,1,0);
    tick();
    chk_head("col_pop1", 1, 7, 1, 1);
    tick();
    chk_head("col_pop2", 0, 7, 1, 0);

    // Reset asserted mid-run with a record queued and a run open.
    drive(1,6,0,0,0);
    tick(); tick(); tick();
    drive(1,1,0,0,0);
    tick();
    chk_head("mid_pre", 1, 6, 3, 1);
    #2;
    clr_n = 1'b0;
    #1;
    chk_head("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    drive(0,0,0,0,0);
    tick();
    clr_n = 1'b1;
    drive(1,2,0,0,0);
    tick();
    chk_head("mid_open", 0, 0, 0, 0);
    drive(0,0,1,0,0);
    tick();
    chk_head("mid_fl", 1, 2, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
